// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the MIPS core front end.
//   Instruction width, default address width, the opcode values the
//   decode stage recognises, and the state encoding of the fetch FSM.
//   opcode_of() extracts the primary opcode field of an instruction word.
package mips_pkg;

   localparam int INSTR_W    = 32;
   localparam int IFU_ADDR_W = 32;

   localparam logic [5:0] OP_R_FORMAT = 6'd0;
   localparam logic [5:0] OP_J        = 6'd2;
   localparam logic [5:0] OP_JAL      = 6'd3;
   localparam logic [5:0] OP_BEQ      = 6'd4;
   localparam logic [5:0] OP_ADDIU    = 6'd9;
   localparam logic [5:0] OP_LW       = 6'd35;
   localparam logic [5:0] OP_SW       = 6'd43;

   typedef enum logic [1:0] {
      IFU_IDLE    = 2'd0,
      IFU_FETCH   = 2'd1,
      IFU_HOLD    = 2'd2,
      IFU_DISCARD = 2'd3
   } ifu_state_t;

   function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] w);
      return w[31:26];
   endfunction

endpackage

// File: rtl/ifu_prefetch_buf.sv
// ifu_prefetch_buf -- one-entry holding register for a prefetched
//   instruction word and its address. Only present when the build defines
//   IFU_PREFETCH_EN; otherwise this file contributes nothing.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load                capture load_data/load_pc, entry becomes valid
//   pop                 entry consumed, becomes empty
//   flush               empty the entry (takes priority over load/pop)
//   load_data, load_pc  word and its address to capture
//   valid, data, pc     current entry
`ifdef IFU_PREFETCH_EN
module ifu_prefetch_buf
   import mips_pkg::*;
#(
   parameter int unsigned ADDR_W = IFU_ADDR_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               pop,
   input  logic               flush,
   input  logic [INSTR_W-1:0] load_data,
   input  logic [ADDR_W-1:0]  load_pc,
   output logic               valid,
   output logic [INSTR_W-1:0] data,
   output logic [ADDR_W-1:0]  pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
         pc    <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         pc    <= load_pc;
      end else if (pop) begin
         valid <= 1'b0;
      end
   end

endmodule
`endif

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit -- sequential instruction fetch front end.
//   Holds the PC, fetches words over a req/ack instruction-memory port and
//   presents them downstream with a valid/ready handshake. Redirects from
//   the datapath (taken branch, J, JAL) replace the PC; misaligned targets
//   are forced to a word boundary and flagged with misalign_err.
//   Optional build macro IFU_PREFETCH_EN adds a one-entry prefetch buffer
//   so the next word is fetched while the current one is held.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   imem_req, imem_addr         fetch request and word address
//   imem_ack, imem_rdata        one-cycle acknowledge with data
//   instr_valid, instr_ready    downstream handshake
//   instr, opcode               fetched word and its [31:26] field
//   instr_pc, instr_pc4         address of instr and address + 4
//   redirect_en, redirect_pc    PC redirect from the datapath
//   misalign_err                one-cycle pulse for a misaligned redirect
module instr_fetch_unit
   import mips_pkg::*;
#(
   parameter int unsigned       ADDR_W   = IFU_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [5:0]         opcode,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic [ADDR_W-1:0]  instr_pc4,
   input  logic               redirect_en,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               misalign_err
);

   ifu_state_t         state, state_nxt;
   logic [ADDR_W-1:0]  pc, pc_nxt;
   // Address of a request that must complete after a redirect moved pc away.
   logic [ADDR_W-1:0]  disc_addr, disc_addr_nxt;
   logic [ADDR_W-1:0]  redir_pc;
   logic [ADDR_W-1:0]  pc_inc;
   logic               handshake;
   logic               out_load;
   logic [INSTR_W-1:0] out_data;
   logic [ADDR_W-1:0]  out_pc;

   assign redir_pc    = {redirect_pc[ADDR_W-1:2], 2'b00};
   assign pc_inc      = pc + ADDR_W'(4);
   assign instr_valid = (state == IFU_HOLD);
   assign handshake   = instr_valid & instr_ready;
   assign opcode      = opcode_of(instr);

`ifdef IFU_PREFETCH_EN
   logic               buf_load, buf_pop, buf_flush, buf_valid;
   logic [INSTR_W-1:0] buf_data;
   logic [ADDR_W-1:0]  buf_pc;

   ifu_prefetch_buf #(.ADDR_W(ADDR_W)) u_prefetch_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (buf_load),
      .pop       (buf_pop),
      .flush     (buf_flush),
      .load_data (imem_rdata),
      .load_pc   (pc),
      .valid     (buf_valid),
      .data      (buf_data),
      .pc        (buf_pc)
   );
`endif

   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      disc_addr_nxt = disc_addr;
      out_load      = 1'b0;
      out_data      = imem_rdata;
      out_pc        = pc;
      imem_req      = 1'b0;
      imem_addr     = pc;
`ifdef IFU_PREFETCH_EN
      buf_load      = 1'b0;
      buf_pop       = 1'b0;
      buf_flush     = 1'b0;
`endif
      unique case (state)
         IFU_IDLE: begin
            if (redirect_en) pc_nxt = redir_pc;
            state_nxt = IFU_FETCH;
         end
         IFU_FETCH: begin
            imem_req = 1'b1;
            if (redirect_en) begin
               // The request for the old pc must still be completed.
               pc_nxt        = redir_pc;
               disc_addr_nxt = pc;
               state_nxt     = imem_ack ? IFU_FETCH : IFU_DISCARD;
            end else if (imem_ack) begin
               out_load  = 1'b1;
               pc_nxt    = pc_inc;
               state_nxt = IFU_HOLD;
            end
         end
         IFU_HOLD: begin
`ifdef IFU_PREFETCH_EN
            imem_req = ~buf_valid;
            if (redirect_en) begin
               pc_nxt    = redir_pc;
               buf_flush = 1'b1;
               if (imem_req && !imem_ack) begin
                  disc_addr_nxt = pc;
                  state_nxt     = IFU_DISCARD;
               end else begin
                  state_nxt = IFU_FETCH;
               end
            end else if (handshake) begin
               if (buf_valid) begin
                  out_load = 1'b1;
                  out_data = buf_data;
                  out_pc   = buf_pc;
                  buf_pop  = 1'b1;
               end else if (imem_ack) begin
                  // Word arrives as the current one leaves: present it directly.
                  out_load = 1'b1;
                  pc_nxt   = pc_inc;
               end else begin
                  // Request (if any) stays outstanding with the same address.
                  state_nxt = IFU_FETCH;
               end
            end else if (imem_req && imem_ack) begin
               buf_load = 1'b1;
               pc_nxt   = pc_inc;
            end
`else
            if (redirect_en) begin
               pc_nxt    = redir_pc;
               state_nxt = IFU_FETCH;
            end else if (handshake) begin
               state_nxt = IFU_FETCH;
            end
`endif
         end
         IFU_DISCARD: begin
            imem_req  = 1'b1;
            imem_addr = disc_addr;
            if (redirect_en) pc_nxt = redir_pc;
            if (imem_ack) state_nxt = IFU_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IFU_IDLE;
         pc           <= RESET_PC;
         disc_addr    <= '0;
         instr        <= '0;
         instr_pc     <= '0;
         instr_pc4    <= '0;
         misalign_err <= 1'b0;
      end else begin
         state        <= state_nxt;
         pc           <= pc_nxt;
         disc_addr    <= disc_addr_nxt;
         misalign_err <= redirect_en & (|redirect_pc[1:0]);
         if (out_load) begin
            instr     <= out_data;
            instr_pc  <= out_pc;
            instr_pc4 <= out_pc + ADDR_W'(4);
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit -- self-checking bench for instr_fetch_unit (default
//   build). A behavioural memory answers requests with address-derived
//   words after a chosen latency; directed scenarios and a randomized run
//   are compared against expectations derived from the fetch rules.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc4;
   logic        redirect_en = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        misalign_err;

   instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr        (instr),
      .opcode       (opcode),
      .instr_pc     (instr_pc),
      .instr_pc4    (instr_pc4),
      .redirect_en  (redirect_en),
      .redirect_pc  (redirect_pc),
      .misalign_err (misalign_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // memory model configuration and state
   logic        lat_rand = 1'b0;
   logic        spurious = 1'b0;
   logic [31:0] slow_addr = 32'hFFFF_FFFF;
   int          slow_lat = 0;
   logic        in_req = 1'b0;
   logic [31:0] hold_addr = '0;
   int          wait_cnt = 0;

   // observations of the current cycle
   logic        o_req, o_valid, o_mis, hs, prot_bad;
   logic [31:0] o_addr, o_instr, o_pc, o_pc4;
   logic [5:0]  o_op;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      if (a == 32'h8)       w = 32'h8C01_0004;   // lw
      else if (a == 32'h20) w = 32'h1000_0037;   // beq
      else                  w = (a * 32'h9E37_79B1) ^ 32'hA5C3_0F00;
      return w;
   endfunction

   function automatic logic [5:0] top6(input logic [31:0] w);
      return w[31:26];
   endfunction

   function automatic int lat_for(input logic [31:0] a);
      if (lat_rand) return int'($urandom_range(0, 3));
      if (a == slow_addr) return slow_lat;
      return 0;
   endfunction

   // One clock cycle: sample outputs at the falling edge, then drive the
   // inputs that the next rising edge will see.
   task automatic cycle(input logic rdy, input logic redir, input logic [31:0] tgt);
      @(negedge clk);
      cyc++;
      o_req = imem_req;   o_addr = imem_addr; o_valid = instr_valid;
      o_instr = instr;    o_op = opcode;      o_pc = instr_pc;
      o_pc4 = instr_pc4;  o_mis = misalign_err;
      prot_bad = in_req && (!o_req || o_addr != hold_addr);
      instr_ready = rdy;
      redirect_en = redir;
      redirect_pc = tgt;
      hs = o_valid && rdy;
      if (o_req) begin
         if (!in_req) begin
            in_req    = 1'b1;
            hold_addr = o_addr;
            wait_cnt  = lat_for(o_addr);
         end
         if (wait_cnt == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(o_addr);
            in_req     = 1'b0;
         end else begin
            wait_cnt--;
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
         end
      end else begin
         imem_ack   = spurious && ($urandom_range(0, 2) == 0);
         imem_rdata = $urandom;
      end
   endtask

   task automatic release_reset();
      instr_ready = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
      imem_ack = 1'b0; imem_rdata = '0;
      in_req = 1'b0; wait_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      release_reset();
   endtask

   task automatic test_reset();
      lat_rand = 1'b0; spurious = 1'b0; slow_addr = 32'h0; slow_lat = 3;
      do_reset();
      cycle(1'b1, 1'b0, 32'h0);           // request for 0 now outstanding
      #2 rst_n = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
      checks++; if (instr !== 32'h0 || opcode !== 6'h0) begin errors++; $display("FAIL rst_instr: got %h/%h expected 0", instr, opcode); end
      checks++; if (instr_pc !== 32'h0 || instr_pc4 !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h/%h expected 0", instr_pc, instr_pc4); end
      checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rst_mis: got %b expected 0", misalign_err); end
      slow_addr = 32'hFFFF_FFFF;
      release_reset();
      imem_ack = 1'b1;                    // stale ack during IDLE must be ignored
      imem_rdata = 32'hDEAD_BEEF;
      cycle(1'b1, 1'b0, 32'h0);
      checks++; if (o_req !== 1'b1 || o_addr !== 32'h0) begin errors++; $display("FAIL rst_first_req: got %b@%h expected 1@0", o_req, o_addr); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_stale_ack: valid got %b expected 0", o_valid); end
      cycle(1'b1, 1'b0, 32'h0);
      checks++; if (o_valid !== 1'b1 || o_instr !== mem_word(32'h0)) begin errors++; $display("FAIL rst_first_instr: got %b/%h expected 1/%h", o_valid, o_instr, mem_word(32'h0)); end
   endtask

   task automatic test_sequential();
      logic [31:0] ea, w;
      lat_rand = 1'b0; spurious = 1'b0; slow_addr = 32'hFFFF_FFFF;
      do_reset();
      for (int c = 1; c <= 9; c++) begin
         cycle(1'b1, 1'b0, 32'h0);
         checks++; if (o_valid !== (c % 2 == 0)) begin errors++; $display("FAIL seq_valid c%0d: got %b expected %b", c, o_valid, (c % 2 == 0)); end
         checks++; if (o_req !== (c % 2 == 1)) begin errors++; $display("FAIL seq_req c%0d: got %b expected %b", c, o_req, (c % 2 == 1)); end
         if (c % 2 == 1) begin
            ea = 32'((c - 1) * 2);
            checks++; if (o_addr !== ea) begin errors++; $display("FAIL seq_addr c%0d: got %h expected %h", c, o_addr, ea); end
         end else begin
            ea = 32'((c - 2) * 2);
            w  = mem_word(ea);
            checks++; if (o_pc !== ea || o_instr !== w) begin errors++; $display("FAIL seq_instr c%0d: got %h@%h expected %h@%h", c, o_instr, o_pc, w, ea); end
            checks++; if (o_op !== top6(w)) begin errors++; $display("FAIL seq_opcode c%0d: got %h expected %h", c, o_op, top6(w)); end
         end
      end
   endtask

   task automatic test_wait_states();
      int n4;
      lat_rand = 1'b0; spurious = 1'b0; slow_addr = 32'h4; slow_lat = 3;
      do_reset();
      n4 = 0;
      for (int c = 1; c <= 10; c++) begin
         cycle(1'b1, 1'b0, 32'h0);
         if (hs && o_pc == 32'h4) n4++;
         if (c >= 3 && c <= 6) begin
            checks++; if (o_req !== 1'b1 || o_addr !== 32'h4 || o_valid !== 1'b0) begin errors++; $display("FAIL wait_hold c%0d: got req %b addr %h valid %b expected 1 4 0", c, o_req, o_addr, o_valid); end
         end
         if (c == 7) begin
            checks++; if (o_valid !== 1'b1 || o_pc !== 32'h4 || o_instr !== mem_word(32'h4)) begin errors++; $display("FAIL wait_deliver: got %b %h@%h expected 1 %h@4", o_valid, o_instr, o_pc, mem_word(32'h4)); end
         end
         if (c == 8) begin
            checks++; if (o_req !== 1'b1 || o_addr !== 32'h8) begin errors++; $display("FAIL wait_next: got %b@%h expected 1@8", o_req, o_addr); end
         end
      end
      checks++; if (n4 != 1) begin errors++; $display("FAIL wait_count: got %0d expected 1", n4); end
      slow_addr = 32'hFFFF_FFFF;
   endtask

   task automatic test_stall();
      lat_rand = 1'b0; spurious = 1'b0; slow_addr = 32'hFFFF_FFFF;
      do_reset();
      for (int c = 1; c <= 12; c++) begin
         cycle(!(c >= 6 && c <= 10), 1'b0, 32'h0);
         if (c >= 6 && c <= 10) begin
            checks++; if (o_valid !== 1'b1 || o_instr !== 32'h8C01_0004 || o_op !== 6'd35) begin errors++; $display("FAIL stall_instr c%0d: got %b %h op %h expected 1 8c010004 op 23", c, o_valid, o_instr, o_op); end
            checks++; if (o_pc !== 32'h8 || o_pc4 !== 32'hC) begin errors++; $display("FAIL stall_pc c%0d: got %h/%h expected 8/c", c, o_pc, o_pc4); end
            checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL stall_req c%0d: got %b expected 0", c, o_req); end
         end
         if (c == 12) begin
            checks++; if (o_req !== 1'b1 || o_addr !== 32'hC) begin errors++; $display("FAIL stall_resume: got %b@%h expected 1@c", o_req, o_addr); end
         end
      end
   endtask

   task automatic test_redirect_outstanding();
      int n10;
      lat_rand = 1'b0; spurious = 1'b0; slow_addr = 32'h10; slow_lat = 2;
      do_reset();
      n10 = 0;
      for (int c = 1; c <= 14; c++) begin
         cycle(1'b1, c == 9, 32'h40);
         if (o_valid && o_pc == 32'h10) n10++;
         if (c == 9) begin
            checks++; if (o_req !== 1'b1 || o_addr !== 32'h10) begin errors++; $display("FAIL rdo_req: got %b@%h expected 1@10", o_req, o_addr); end
         end
         if (c == 10 || c == 11) begin
            checks++; if (o_req !== 1'b1 || o_addr !== 32'h10 || o_valid !== 1'b0) begin errors++; $display("FAIL rdo_discard c%0d: got %b %h %b expected 1 10 0", c, o_req, o_addr, o_valid); end
         end
         if (c == 12) begin
            checks++; if (o_req !== 1'b1 || o_addr !== 32'h40 || o_valid !== 1'b0) begin errors++; $display("FAIL rdo_refetch: got %b %h %b expected 1 40 0", o_req, o_addr, o_valid); end
         end
         if (c == 13) begin
            checks++; if (o_valid !== 1'b1 || o_pc !== 32'h40 || o_instr !== mem_word(32'h40)) begin errors++; $display("FAIL rdo_target: got %b %h@%h expected 1 %h@40", o_valid, o_instr, o_pc, mem_word(32'h40)); end
         end
      end
      checks++; if (n10 != 0) begin errors++; $display("FAIL rdo_dropped: got %0d expected 0", n10); end
      slow_addr = 32'hFFFF_FFFF;
   endtask

   task automatic test_redirect_handshake();
      int nbeq, n24;
      lat_rand = 1'b0; spurious = 1'b0; slow_addr = 32'hFFFF_FFFF;
      do_reset();
      nbeq = 0; n24 = 0;
      for (int c = 1; c <= 21; c++) begin
         cycle(1'b1, c == 18, 32'h100);
         if (hs && o_pc == 32'h20) nbeq++;
         if (o_valid && o_pc == 32'h24) n24++;
         if (c == 18) begin
            checks++; if (o_valid !== 1'b1 || o_pc !== 32'h20 || o_op !== 6'd4) begin errors++; $display("FAIL rdh_beq: got %b %h op %h expected 1 20 op 04", o_valid, o_pc, o_op); end
         end
         if (c == 19) begin
            checks++; if (o_req !== 1'b1 || o_addr !== 32'h100) begin errors++; $display("FAIL rdh_req: got %b@%h expected 1@100", o_req, o_addr); end
         end
         if (c == 20) begin
            checks++; if (o_valid !== 1'b1 || o_pc !== 32'h100 || o_pc4 !== 32'h104) begin errors++; $display("FAIL rdh_target: got %b %h/%h expected 1 100/104", o_valid, o_pc, o_pc4); end
         end
      end
      checks++; if (nbeq != 1 || n24 != 0) begin errors++; $display("FAIL rdh_count: got beq %0d pc24 %0d expected 1 0", nbeq, n24); end
   endtask

   task automatic test_misalign();
      lat_rand = 1'b0; spurious = 1'b0; slow_addr = 32'hFFFF_FFFF;
      do_reset();
      for (int c = 1; c <= 5; c++) begin
         cycle(c != 2, c == 2, 32'h103);
         if (c == 2) begin
            checks++; if (o_mis !== 1'b0) begin errors++; $display("FAIL mis_before: got %b expected 0", o_mis); end
         end
         if (c == 3) begin
            checks++; if (o_mis !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b expected 1", o_mis); end
            checks++; if (o_req !== 1'b1 || o_addr !== 32'h100) begin errors++; $display("FAIL mis_addr: got %b@%h expected 1@100", o_req, o_addr); end
         end
         if (c == 4) begin
            checks++; if (o_mis !== 1'b0) begin errors++; $display("FAIL mis_width: got %b expected 0", o_mis); end
            checks++; if (o_valid !== 1'b1 || o_pc !== 32'h100 || o_instr !== mem_word(32'h100)) begin errors++; $display("FAIL mis_instr: got %b %h@%h expected 1 %h@100", o_valid, o_instr, o_pc, mem_word(32'h100)); end
         end
      end
   endtask

   task automatic test_wrap();
      lat_rand = 1'b0; spurious = 1'b0; slow_addr = 32'hFFFF_FFFF;
      do_reset();
      for (int c = 1; c <= 7; c++) begin
         cycle(1'b1, c == 2, 32'hFFFF_FFFC);
         if (c == 3) begin
            checks++; if (o_req !== 1'b1 || o_addr !== 32'hFFFF_FFFC || o_mis !== 1'b0) begin errors++; $display("FAIL wrap_req: got %b@%h mis %b expected 1@fffffffc mis 0", o_req, o_addr, o_mis); end
         end
         if (c == 4) begin
            checks++; if (o_valid !== 1'b1 || o_pc !== 32'hFFFF_FFFC || o_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %b %h/%h expected 1 fffffffc/0", o_valid, o_pc, o_pc4); end
         end
         if (c == 5) begin
            checks++; if (o_req !== 1'b1 || o_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: got %b@%h expected 1@0", o_req, o_addr); end
         end
         if (c == 6) begin
            checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_pc4 !== 32'h4) begin errors++; $display("FAIL wrap_zero: got %b %h/%h expected 1 0/4", o_valid, o_pc, o_pc4); end
         end
      end
   endtask

   // Reference: delivered instructions follow the program order
   // exp_pc, exp_pc+4, ...; a redirect replaces the next expected address
   // after any same-cycle handshake; misalign_err follows a misaligned
   // redirect by one cycle; requests hold address until acknowledged.
   task automatic test_random();
      logic [31:0] exp_pc, tgt, w;
      logic        rdy, redir, prev_mis;
      int          delivered;
      lat_rand = 1'b1; spurious = 1'b1;
      do_reset();
      exp_pc = 32'h0; prev_mis = 1'b0; delivered = 0;
      for (int c = 1; c <= 3000; c++) begin
         rdy   = ($urandom_range(0, 9) < 7);
         redir = ($urandom_range(0, 15) == 0);
         tgt   = $urandom;
         if ($urandom_range(0, 1) == 1) tgt[1:0] = 2'b00;
         cycle(rdy, redir, tgt);
         checks++; if (prot_bad !== 1'b0) begin errors++; $display("FAIL rnd_protocol c%0d: got req %b addr %h expected 1 %h", c, o_req, o_addr, hold_addr); end
         checks++; if (o_mis !== prev_mis) begin errors++; $display("FAIL rnd_mis c%0d: got %b expected %b", c, o_mis, prev_mis); end
         if (hs) begin
            w = mem_word(exp_pc);
            delivered++;
            checks++; if (o_pc !== exp_pc || o_instr !== w) begin errors++; $display("FAIL rnd_instr c%0d: got %h@%h expected %h@%h", c, o_instr, o_pc, w, exp_pc); end
            checks++; if (o_pc4 !== exp_pc + 32'h4 || o_op !== top6(w)) begin errors++; $display("FAIL rnd_pc4_op c%0d: got %h op %h expected %h op %h", c, o_pc4, o_op, exp_pc + 32'h4, top6(w)); end
            exp_pc = exp_pc + 32'h4;
         end
         if (redir) exp_pc = {tgt[31:2], 2'b00};
         prev_mis = redir && (tgt[1:0] != 2'b00);
      end
      checks++; if (delivered < 200) begin errors++; $display("FAIL rnd_progress: got %0d instructions expected at least 200", delivered); end
      lat_rand = 1'b0; spurious = 1'b0;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_wait_states();
      test_stall();
      test_redirect_outstanding();
      test_redirect_handshake();
      test_misalign();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
